// File: rtl/activation_cache.sv
// Activation history cache: pairs each accepted C-channel sample with the sample
// DILATION accepts earlier (zero until that much history exists).
module activation_cache #(
  parameter int W        = 16,
  parameter int C        = 4,
  parameter int DILATION = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic signed [W-1:0] in_sample [0:C-1],
  input  logic                in_v,
  output logic                in_ready,
  output logic signed [W-1:0] out [0:2*C-1],
  output logic                out_v,
  input  logic                out_ready
);

  localparam int PW = (DILATION > 1) ? $clog2(DILATION) : 1;
  localparam int FW = $clog2(DILATION + 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(DILATION - 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(DILATION);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [C*W-1:0]      mem_r [0:DILATION-1];
  logic [C*W-1:0]      in_flat_s;
  logic [C*W-1:0]      cur_r;
  logic [C*W-1:0]      rd_data_r;
  logic signed [W-1:0] out_r [0:2*C-1];
  logic [PW-1:0]       wr_ptr_r;
  logic [FW-1:0]       fill_cnt_r;
  logic                in_ready_r;
  logic                out_v_r;
  logic                accept_s;
  logic                we_s;

  // Flatten the per-channel input words into one slot-wide word.
  always_comb begin
    in_flat_s = '0;
    for (int c = 0; c < C; c++) begin
      in_flat_s[c*W +: W] = in_sample[c];
    end
  end

  // Next-state decode; clear overrides every state.
  always_comb begin
    state_nxt_s = state_r;
    if (clear) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    if (in_v) state_nxt_s = LOOKUP; else state_nxt_s = IDLE;
        LOOKUP:  state_nxt_s = PRESENT;
        PRESENT: if (out_v_r && out_ready) state_nxt_s = IDLE; else state_nxt_s = PRESENT;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  assign accept_s = (state_r == IDLE) && in_v && !clear;
  assign we_s     = (state_r == LOOKUP) && !clear;

  // History storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[wr_ptr_r] <= cur_r;
    end
  end

  // Control state, pointers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      wr_ptr_r   <= '0;
      fill_cnt_r <= '0;
      in_ready_r <= 1'b1;
      out_v_r    <= 1'b0;
      cur_r      <= '0;
      rd_data_r  <= '0;
      for (int i = 0; i < 2*C; i++) out_r[i] <= '0;
    end else begin
      state_r    <= state_nxt_s;
      in_ready_r <= (state_nxt_s == IDLE);
      // out_v rises one cycle into PRESENT, once out has settled.
      out_v_r    <= (state_nxt_s == PRESENT) && (state_r == PRESENT);
      if (accept_s) begin
        cur_r     <= in_flat_s;
        rd_data_r <= mem_r[wr_ptr_r];
      end else begin
        cur_r     <= cur_r;
        rd_data_r <= rd_data_r;
      end
      if (clear) begin
        wr_ptr_r   <= '0;
        fill_cnt_r <= '0;
      end else if (state_r == LOOKUP) begin
        // rd_data_r was captured before this slot is overwritten: read-before-write.
        for (int c = 0; c < C; c++) begin
          if (fill_cnt_r == FILL_FULL) out_r[c] <= rd_data_r[c*W +: W];
          else                         out_r[c] <= '0;
          out_r[C+c] <= cur_r[c*W +: W];
        end
        if (wr_ptr_r == PTR_LAST) wr_ptr_r <= '0;
        else                      wr_ptr_r <= wr_ptr_r + PW'(1);
        if (fill_cnt_r != FILL_FULL) fill_cnt_r <= fill_cnt_r + FW'(1);
        else                         fill_cnt_r <= fill_cnt_r;
      end else begin
        wr_ptr_r   <= wr_ptr_r;
        fill_cnt_r <= fill_cnt_r;
      end
    end
  end

  assign in_ready = in_ready_r;
  assign out_v    = out_v_r;
  assign out      = out_r;

endmodule

// File: tb/tb_activation_cache.sv
// Directed bench for activation_cache: a DILATION=4 instance and a DILATION=1 instance.
module tb_activation_cache;

  logic clk;
  logic rst;
  logic clear;
  logic signed [15:0] s4 [0:3];
  logic signed [15:0] o4 [0:7];
  logic in_v4, rdy4, ov4, ordy4;
  logic signed [15:0] s1 [0:3];
  logic signed [15:0] o1 [0:7];
  logic in_v1, rdy1, ov1, ordy1, clr1;
  logic [63:0] past4, cur4, past1, cur1;
  int vecs;
  int errs;

  activation_cache #(.W(16), .C(4), .DILATION(4)) u4 (
    .clk(clk), .rst(rst), .clear(clear), .in_sample(s4), .in_v(in_v4),
    .in_ready(rdy4), .out(o4), .out_v(ov4), .out_ready(ordy4));

  activation_cache #(.W(16), .C(4), .DILATION(1)) u1 (
    .clk(clk), .rst(rst), .clear(clr1), .in_sample(s1), .in_v(in_v1),
    .in_ready(rdy1), .out(o1), .out_v(ov1), .out_ready(ordy1));

  assign past4 = {o4[0], o4[1], o4[2], o4[3]};
  assign cur4  = {o4[4], o4[5], o4[6], o4[7]};
  assign past1 = {o1[0], o1[1], o1[2], o1[3]};
  assign cur1  = {o1[4], o1[5], o1[6], o1[7]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] pk(input int b);
    return {16'(b), 16'(b + 1), 16'(b + 2), 16'(b + 3)};
  endfunction

  function automatic logic [63:0] rep(input int v);
    return {4{16'(v)}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // Send one sample (channel c = b+c) and check latency, past and current taps.
  task automatic xfer4(input int b, input logic [63:0] exp_past, input string tag, input bit hs);
    int n = 0;
    while (!rdy4 && n < 16) begin step(); n++; end
    chk({tag, "_ready"}, 64'(rdy4), 64'd1);
    for (int c = 0; c < 4; c++) s4[c] = 16'(b + c);
    in_v4 = 1'b1;
    step();
    in_v4 = 1'b0;
    for (int c = 0; c < 4; c++) s4[c] = 16'hBEEF;
    chk({tag, "_busy"}, 64'(rdy4), 64'd0);
    step();
    chk({tag, "_ov_k1"}, 64'(ov4), 64'd0);
    step();
    chk({tag, "_ov_k2"}, 64'(ov4), 64'd1);
    chk({tag, "_past"}, past4, exp_past);
    chk({tag, "_cur"}, cur4, pk(b));
    if (hs) begin
      step();
      chk({tag, "_hs_ov"}, 64'(ov4), 64'd0);
      chk({tag, "_hs_rdy"}, 64'(rdy4), 64'd1);
    end
  endtask

  task automatic xfer1(input int v, input int pv, input string tag);
    for (int c = 0; c < 4; c++) s1[c] = 16'(v);
    in_v1 = 1'b1;
    step();
    in_v1 = 1'b0;
    step();
    step();
    chk({tag, "_ov"}, 64'(ov1), 64'd1);
    chk({tag, "_past"}, past1, rep(pv));
    chk({tag, "_cur"}, cur1, rep(v));
    step();
    chk({tag, "_hs"}, 64'(ov1), 64'd0);
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    rst = 1'b0; clear = 1'b0; clr1 = 1'b0;
    in_v4 = 1'b0; ordy4 = 1'b1; in_v1 = 1'b0; ordy1 = 1'b1;
    for (int c = 0; c < 4; c++) begin s4[c] = '0; s1[c] = '0; end
    step();
    step();
    chk("rst_rdy4", 64'(rdy4), 64'd1);
    chk("rst_ov4", 64'(ov4), 64'd0);
    chk("rst_past4", past4, 64'd0);
    chk("rst_cur4", cur4, 64'd0);
    chk("rst_rdy1", 64'(rdy1), 64'd1);
    chk("rst_ov1", 64'(ov1), 64'd0);
    rst = 1'b1;

    // Causal padding: first four outputs see zero past taps.
    for (int n = 1; n <= 6; n++)
      xfer4(16 * n, (n <= 4) ? 64'd0 : pk(16 * (n - 4)), $sformatf("causal%0d", n), 1'b1);

    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_rdy", 64'(rdy4), 64'd1);

    // Wrap-around: history pointer wraps three times.
    for (int n = 1; n <= 14; n++)
      xfer4(256 + 16 * n, (n <= 4) ? 64'd0 : pk(256 + 16 * (n - 4)), $sformatf("wrap%0d", n), 1'b1);

    // Backpressure: out held while in_v toggles data.
    ordy4 = 1'b0;
    xfer4(16'h600, pk(256 + 16 * 11), "bp", 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_v4 = 1'b1;
      for (int c = 0; c < 4; c++) s4[c] = 16'(16'h700 + 4 * i + c);
      step();
      chk($sformatf("bp_ov%0d", i), 64'(ov4), 64'd1);
      chk($sformatf("bp_rdy%0d", i), 64'(rdy4), 64'd0);
      chk($sformatf("bp_past%0d", i), past4, pk(256 + 16 * 11));
      chk($sformatf("bp_cur%0d", i), cur4, pk(16'h600));
    end
    in_v4 = 1'b0;
    ordy4 = 1'b1;
    step();
    chk("bp_rel_ov", 64'(ov4), 64'd0);
    chk("bp_rel_rdy", 64'(rdy4), 64'd1);
    xfer4(16'h680, pk(256 + 16 * 12), "bp_next", 1'b1);

    // clear during LOOKUP with a competing in_v.
    for (int c = 0; c < 4; c++) s4[c] = 16'(16'h7F0 + c);
    in_v4 = 1'b1;
    step();
    clear = 1'b1;
    for (int c = 0; c < 4; c++) s4[c] = 16'(16'h7A0 + c);
    step();
    clear = 1'b0;
    in_v4 = 1'b0;
    chk("lk_clr_rdy", 64'(rdy4), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("lk_clr_ov%0d", i), 64'(ov4), 64'd0);
      step();
    end
    for (int j = 1; j <= 5; j++)
      xfer4(16'h800 + 16 * j, (j <= 4) ? 64'd0 : pk(16'h810), $sformatf("clr%0d", j), 1'b1);

    // Asynchronous reset while presenting.
    ordy4 = 1'b0;
    xfer4(16'h900, pk(16'h820), "pre_rst", 1'b0);
    rst = 1'b0;
    #1;
    chk("arst_ov", 64'(ov4), 64'd0);
    chk("arst_rdy", 64'(rdy4), 64'd1);
    chk("arst_past", past4, 64'd0);
    chk("arst_cur", cur4, 64'd0);
    step();
    rst = 1'b1;
    ordy4 = 1'b1;
    xfer4(16'h980, 64'd0, "post_rst", 1'b1);

    // DILATION=1: past tap is the previous sample.
    xfer1(10, 0, "d1_a");
    xfer1(20, 10, "d1_b");
    xfer1(30, 20, "d1_c");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
